serial_rx8: RTL and testbench

SERIAL_RX8 -- requirements
Module: serial_rx8

---
 rtl/serial_rx8_pkg.sv | 20 ++
 rtl/serial_rx8_dfrl.sv | 19 +
 rtl/serial_rx8.sv | 87 ++++++++
 tb/tb_serial_rx8.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_rx8_pkg.sv
// Shared definitions for the 8-bit framed serial receiver: state encoding,
// frame geometry and the slot decoder used to steer incoming bits.
package serial_rx8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    STOP = 2'b10
  } state_e;

  localparam int FRAME_BITS = 8;
  localparam int STOP_SLOT  = 8;

  // One-hot select of the hold bit written in a given data slot.
  function automatic logic [0:FRAME_BITS-1] slot_decode(input logic [2:0] idx);
    slot_decode      = '0;
    slot_decode[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/serial_rx8_dfrl.sv
// Library cell dfrl: one-bit flop with load enable and synchronous
// active-low reset.
module dfrl (
  input  logic clk,
  input  logic reset_,
  input  logic load,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!reset_) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/serial_rx8.sv
// Receives 9-slot serial frames (8 data + stop) aligned by a sync strobe and
// publishes each good frame on dout with a one-cycle valid pulse.
module serial_rx8
  import serial_rx8_pkg::*;
#(
  parameter bit STOP_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       sin,
  input  logic       sync,
  output logic [0:7] dout,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [0:FRAME_BITS-1]   hold_ld;
  logic                    dout_ld;
  logic [0:FRAME_BITS-1]   hold;

  // A sync strobe always wins: it restarts the frame from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    hold_ld = '0;
    dout_ld = 1'b0;
    if (sync) begin
      state_d = DATA;
      cnt_d   = 3'd1;
      hold_ld = slot_decode(3'd0);
    end else begin
      case (state_q)
        DATA: begin
          hold_ld = slot_decode(cnt_q);
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'(STOP_SLOT - 1)) state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          if (sin || (STOP_CHECK == 1'b0)) begin
            dout_ld = 1'b1;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar i = 0; i < FRAME_BITS; i++) begin : g_bit
    dfrl u_hold (.clk(clk), .reset_(reset_), .load(hold_ld[i]), .d(sin),     .q(hold[i]));
    dfrl u_dout (.clk(clk), .reset_(reset_), .load(dout_ld),    .d(hold[i]), .q(dout[i]));
  end

  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_serial_rx8.sv
// Directed bench for serial_rx8: frames are driven in sequence, expected
// outcomes are queued at sync time and checked when their due cycle arrives.
module tb_serial_rx8;

  logic       clk = 1'b0;
  logic       reset_;
  logic       sin;
  logic       sync;
  logic [0:7] dout_c, dout_n;
  logic       valid_c, valid_n, err_c, err_n, busy_c, busy_n;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  typedef struct {
    int         due;
    logic       is_good;
    logic [0:7] dout_c;
    logic [0:7] dout_n;
  } exp_t;
  exp_t sb[$];

  logic [0:7] model_c = '0;
  logic [0:7] model_n = '0;
  logic       busy_log [0:4095];

  serial_rx8 #(.STOP_CHECK(1'b1)) dut (
    .clk(clk), .reset_(reset_), .sin(sin), .sync(sync),
    .dout(dout_c), .valid(valid_c), .err(err_c), .busy(busy_c)
  );

  serial_rx8 #(.STOP_CHECK(1'b0)) dut_nc (
    .clk(clk), .reset_(reset_), .sin(sin), .sync(sync),
    .dout(dout_n), .valid(valid_n), .err(err_n), .busy(busy_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Scoreboard: pulses must appear exactly at the queued due cycle.
  always @(negedge clk) begin
    busy_log[cyc % 4096] = busy_c;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("overdue", 32'(sb[0].due), 32'(cyc));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("valid_c", {31'b0, valid_c}, {31'b0, e.is_good});
      chk("err_c",   {31'b0, err_c},   {31'b0, !e.is_good});
      chk("dout_c",  {24'b0, dout_c},  {24'b0, e.dout_c});
      chk("valid_n", {31'b0, valid_n}, 32'd1);
      chk("err_n",   {31'b0, err_n},   32'd0);
      chk("dout_n",  {24'b0, dout_n},  {24'b0, e.dout_n});
    end else if (valid_c || err_c || valid_n || err_n) begin
      chk("stray_pulse", {28'b0, valid_c, err_c, valid_n, err_n}, 32'd0);
    end
  end

  task automatic step(input logic s, input logic sy);
    sin  = s;
    sync = sy;
    @(posedge clk);
    #1;
  endtask

  // Drives nslots slots of a frame; only a full 9-slot frame is expected to complete.
  task automatic frame(input logic [0:7] d, input logic stopb, input int nslots);
    if (nslots == 9) begin
      exp_t e;
      if (stopb) model_c = d;
      model_n   = d;
      e.due     = cyc + 9;
      e.is_good = stopb;
      e.dout_c  = model_c;
      e.dout_n  = model_n;
      sb.push_back(e);
    end
    for (int i = 0; i < nslots; i++) begin
      if (i < 8) step(d[i], (i == 0));
      else       step(stopb, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {dout_c, dout_n, 10'b0, valid_c, err_c, busy_c, valid_n, err_n, busy_n}, 32'd0);
  endtask

  initial begin
    int t0;
    logic [0:7] snap;
    reset_ = 1'b0;
    sin    = 1'b1;
    sync   = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk_all_zero("reset_state");
    reset_ = 1'b1;
    idle(2);

    // Good frame, then bad stop bit (err on checking DUT, valid on the other).
    frame(8'b10100101, 1'b1, 9);
    idle(2);
    frame(8'b10100101, 1'b0, 9);
    idle(2);
    chk("dout_after_err", {24'b0, dout_c}, 32'b10100101);

    // Reset clears a published dout, then a bad-stop frame leaves it at zero.
    reset_ = 1'b0;
    step(1'b0, 1'b0);
    reset_ = 1'b1;
    model_c = '0;
    model_n = '0;
    chk_all_zero("reset_clears");
    frame(8'b10100101, 1'b0, 9);
    idle(2);
    chk("dout_stays_zero", {24'b0, dout_c}, 32'd0);

    // Restart: sync re-asserted four slots in.
    frame(8'b11110000, 1'b1, 4);
    frame(8'b00001111, 1'b1, 9);
    idle(2);

    // Back-to-back frames with busy profile.
    t0 = cyc;
    frame(8'b11001100, 1'b1, 9);
    frame(8'b00110011, 1'b1, 9);
    idle(2);
    for (int k = 1; k <= 18; k++) begin
      chk("busy_b2b", {31'b0, busy_log[(t0 + k) % 4096]}, {31'b0, !(k == 9 || k == 18)});
    end

    // Reset mid-frame at T+5, release, sync at T+7.
    frame(8'b01011010, 1'b1, 5);
    reset_ = 1'b0;
    step(1'b1, 1'b0);
    reset_ = 1'b1;
    model_c = '0;
    model_n = '0;
    chk_all_zero("midframe_reset");
    step(1'b1, 1'b0);
    frame(8'b01100110, 1'b1, 9);
    idle(2);

    // Random sin with no sync: nothing may change.
    snap = dout_c;
    for (int i = 0; i < 50; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      chk("idle_busy", {31'b0, busy_c}, 32'd0);
    end
    chk("idle_dout", {24'b0, dout_c}, {24'b0, snap});

    idle(3);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
